// File: rtl/bsr_pkg.sv
// rtl/bsr_pkg.sv - shared mode enum and select-code helpers for the boundary-scan chain selector
package bsr_pkg;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_CONCAT = 2'd1,
        MODE_BYPASS = 2'd2
    } bsr_mode_e;

    function automatic int concat_code(input int sel_width);
        return (1 << sel_width) - 1;
    endfunction

    // The all-ones code wins over the chain range so CONCAT stays reachable for any width.
    function automatic bsr_mode_e decode_mode(input int code, input int chain_num, input int sel_width);
        if (code == concat_code(sel_width)) begin
            return MODE_CONCAT;
        end
        if (code < chain_num) begin
            return MODE_SINGLE;
        end
        return MODE_BYPASS;
    endfunction

endpackage

// File: rtl/bsr_sel_reg.sv
// rtl/bsr_sel_reg.sv - select shift register, update, error flag; BSR_SEL_PARITY_EN adds an even-parity MSB
module bsr_sel_reg
    import bsr_pkg::*;
#(
    parameter int CHAIN_NUM = 4,
    parameter int SEL_WIDTH = 3
) (
    input  logic                 tck,
    input  logic                 rst,
    input  logic                 tdi,
    input  logic                 shift_sel,
    input  logic                 update_sel,
    output logic                 sr_lsb,
    output logic [SEL_WIDTH-1:0] sel_active,
    output logic                 sel_err
);

`ifdef BSR_SEL_PARITY_EN
    localparam int SR_W = SEL_WIDTH + 1;
`else
    localparam int SR_W = SEL_WIDTH;
`endif

    logic [SR_W-1:0]      r_sr;
    logic [SR_W-1:0]      w_sr_next;
    logic [SEL_WIDTH-1:0] r_active;
    logic                 r_err;
    logic [SEL_WIDTH-1:0] w_code;
    logic                 w_update;
    logic                 w_accept;
    logic                 w_in_range;

    generate
        if (SR_W == 1) begin : g_sr_one
            assign w_sr_next = tdi;
        end else begin : g_sr_many
            assign w_sr_next = {tdi, r_sr[SR_W-1:1]};
        end
    endgenerate

    assign w_code     = r_sr[SEL_WIDTH-1:0];
    assign w_update   = update_sel & ~shift_sel;
    assign w_in_range = (decode_mode(32'(w_code), CHAIN_NUM, SEL_WIDTH) != MODE_BYPASS);

`ifdef BSR_SEL_PARITY_EN
    assign w_accept = ~(^r_sr);
`else
    assign w_accept = 1'b1;
`endif

    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            r_sr     <= '0;
            r_active <= '0;
            r_err    <= 1'b0;
        end else if (shift_sel) begin
            r_sr <= w_sr_next;
        end else if (w_update) begin
            if (w_accept) begin
                r_active <= w_code;
                r_err    <= ~w_in_range;
            end else begin
                r_err    <= 1'b1;
            end
        end
    end

    assign sr_lsb     = r_sr[0];
    assign sel_active = r_active;
    assign sel_err    = r_err;

endmodule

// File: rtl/bsr_chain_select.sv
// rtl/bsr_chain_select.sv - routes TDI/TDO through one, all, or none of CHAIN_NUM boundary-scan chains
module bsr_chain_select
    import bsr_pkg::*;
#(
    parameter int CHAIN_NUM = 4,
    parameter int SEL_WIDTH = $clog2(CHAIN_NUM + 1)
) (
    input  logic                 tck,
    input  logic                 rst,
    input  logic                 tdi,
    input  logic                 shift_sel,
    input  logic                 update_sel,
    input  logic                 shift_dr,
    input  logic [CHAIN_NUM-1:0] bsr_so,
    output logic [CHAIN_NUM-1:0] bsr_si,
    output logic [CHAIN_NUM-1:0] chain_shift_en,
    output logic                 scan_out,
    output logic [SEL_WIDTH-1:0] sel_active,
    output logic                 sel_err
);

    logic      w_sr_lsb;
    logic      w_src;
    bsr_mode_e w_mode;
    logic      r_bypass;
    logic      r_scan_out;

    bsr_sel_reg #(
        .CHAIN_NUM (CHAIN_NUM),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_sel_reg (
        .tck        (tck),
        .rst        (rst),
        .tdi        (tdi),
        .shift_sel  (shift_sel),
        .update_sel (update_sel),
        .sr_lsb     (w_sr_lsb),
        .sel_active (sel_active),
        .sel_err    (sel_err)
    );

    assign w_mode = decode_mode(32'(sel_active), CHAIN_NUM, SEL_WIDTH);

    always_comb begin
        bsr_si         = '0;
        chain_shift_en = '0;
        w_src          = r_bypass;
        case (w_mode)
            MODE_SINGLE: begin
                for (int i = 0; i < CHAIN_NUM; i++) begin
                    if (sel_active == SEL_WIDTH'(i)) begin
                        bsr_si[i]         = tdi;
                        chain_shift_en[i] = shift_dr;
                        w_src             = bsr_so[i];
                    end
                end
            end
            MODE_CONCAT: begin
                bsr_si[0] = tdi;
                for (int i = 1; i < CHAIN_NUM; i++) begin
                    bsr_si[i] = bsr_so[i-1];
                end
                chain_shift_en = {CHAIN_NUM{shift_dr}};
                w_src          = bsr_so[CHAIN_NUM-1];
            end
            default: begin
                w_src = r_bypass;
            end
        endcase
        // Chains must not move while the select register is being loaded.
        if (shift_sel) begin
            chain_shift_en = '0;
        end
    end

    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            r_bypass   <= 1'b0;
            r_scan_out <= 1'b0;
        end else begin
            if ((w_mode == MODE_BYPASS) && shift_dr) begin
                r_bypass <= tdi;
            end
            if (shift_sel) begin
                r_scan_out <= w_sr_lsb;
            end else if (shift_dr) begin
                r_scan_out <= w_src;
            end
        end
    end

    assign scan_out = r_scan_out;

endmodule

// File: tb/tb_bsr_chain_select.sv
// tb/tb_bsr_chain_select.sv - randomized bench for bsr_chain_select against a queue-based reference model
module tb_bsr_chain_select;

    localparam int CN = 4;
    localparam int SW = 3;
`ifdef BSR_SEL_PARITY_EN
    localparam int SRW = SW + 1;
`else
    localparam int SRW = SW;
`endif

    logic          tck = 1'b0;
    logic          rst = 1'b1;
    logic          tdi = 1'b0;
    logic          shift_sel = 1'b0;
    logic          update_sel = 1'b0;
    logic          shift_dr = 1'b0;
    logic [CN-1:0] bsr_so = '0;
    logic [CN-1:0] bsr_si;
    logic [CN-1:0] chain_shift_en;
    logic          scan_out;
    logic [SW-1:0] sel_active;
    logic          sel_err;

    int n_vec = 0;
    int n_err = 0;

    int m_sr[$];
    int m_act, m_err, m_byp, m_scan;

    bsr_chain_select #(.CHAIN_NUM(CN), .SEL_WIDTH(SW)) dut (
        .tck            (tck),
        .rst            (rst),
        .tdi            (tdi),
        .shift_sel      (shift_sel),
        .update_sel     (update_sel),
        .shift_dr       (shift_dr),
        .bsr_so         (bsr_so),
        .bsr_si         (bsr_si),
        .chain_shift_en (chain_shift_en),
        .scan_out       (scan_out),
        .sel_active     (sel_active),
        .sel_err        (sel_err)
    );

    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // 0 = single chain, 1 = all chains in series, 2 = bypass
    function automatic int mode_of(input int code);
        if (code == (1 << SW) - 1) return 1;
        if (code < CN) return 0;
        return 2;
    endfunction

    function automatic int sr_code();
        int c = 0;
        for (int i = 0; i < SW; i++) c += m_sr[i] * (1 << i);
        return c;
    endfunction

    task automatic model_reset();
        m_sr.delete();
        for (int i = 0; i < SRW; i++) m_sr.push_back(0);
        m_act = 0; m_err = 0; m_byp = 0; m_scan = 0;
    endtask

    task automatic cycle(input logic t, input logic ss, input logic us, input logic sd, input logic [CN-1:0] so);
        int mode, exp_en, exp_si, src, code, par;
        tdi = t; shift_sel = ss; update_sel = us; shift_dr = sd; bsr_so = so;
        mode = mode_of(m_act);
        exp_en = 0; exp_si = 0; src = m_byp;
        if (mode == 0) begin
            exp_si = int'(t) * (1 << m_act);
            exp_en = int'(sd) * (1 << m_act);
            src    = int'(so[m_act]);
        end else if (mode == 1) begin
            exp_si = (int'(so) * 2 + int'(t)) % (1 << CN);
            exp_en = sd ? (1 << CN) - 1 : 0;
            src    = int'(so[CN-1]);
        end
        if (ss) exp_en = 0;
        @(negedge tck);
        check("chain_shift_en", chain_shift_en, exp_en);
        check("bsr_si", bsr_si, exp_si);
        check("scan_out", scan_out, m_scan);
        check("sel_active", sel_active, m_act);
        check("sel_err", sel_err, m_err);
        if (ss) m_scan = m_sr[0];
        else if (sd) m_scan = src;
        if (mode == 2 && sd) m_byp = int'(t);
        if (ss) begin
            void'(m_sr.pop_front());
            m_sr.push_back(int'(t));
        end else if (us) begin
            code = sr_code();
            par = 0;
            foreach (m_sr[i]) par ^= m_sr[i];
`ifndef BSR_SEL_PARITY_EN
            par = 0;
`endif
            if (par == 0) begin
                m_act = code;
                m_err = (mode_of(code) == 2) ? 1 : 0;
            end else begin
                m_err = 1;
            end
        end
        @(posedge tck);
        #1;
    endtask

    task automatic load_sel(input int code);
        int p = 0;
        for (int i = 0; i < SW; i++) begin
            cycle(1'((code >> i) & 1), 1'b1, 1'b0, 1'b0, CN'($urandom));
            p ^= (code >> i) & 1;
        end
`ifdef BSR_SEL_PARITY_EN
        cycle(1'(p), 1'b1, 1'b0, 1'b0, CN'($urandom));
`endif
        cycle(1'b0, 1'b0, 1'b1, 1'b0, CN'($urandom));
    endtask

    task automatic rst_pulse();
        #2;
        rst = 1'b1;
        #1;
        check("rst_scan_out", scan_out, 0);
        check("rst_sel_active", sel_active, 0);
        check("rst_sel_err", sel_err, 0);
        model_reset();
        @(posedge tck);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge tck);
        #1;
        check("reset_scan_out", scan_out, 0);
        check("reset_sel_active", sel_active, 0);
        check("reset_sel_err", sel_err, 0);
        check("reset_bsr_si", bsr_si, 0);
        rst = 1'b0;

        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
        check("single0_scan", scan_out, 1);

        load_sel(2);
        check("load2_sel", sel_active, 3'b010);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b0100);
        check("single2_scan", scan_out, 1);

        load_sel(7);
        check("concat_sel", sel_active, 3'b111);
        repeat (6) cycle(1'($urandom), 1'b0, 1'b0, 1'b1, CN'($urandom));

        load_sel(5);
        check("bypass_err", sel_err, 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, CN'($urandom));
        cycle(1'b0, 1'b0, 1'b0, 1'b1, CN'($urandom));
        check("bypass_lat_a", scan_out, 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, CN'($urandom));
        check("bypass_lat_b", scan_out, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, CN'($urandom));
        check("bypass_lat_c", scan_out, 1);
        load_sel(0);
        check("err_cleared", sel_err, 0);

        load_sel(3);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, CN'($urandom));
        check("shift_wins_update", sel_active, 3);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b1000);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, CN'($urandom));
        rst_pulse();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, CN'($urandom));
        check("post_rst_sel", sel_active, 0);

`ifdef BSR_SEL_PARITY_EN
        load_sel(1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, CN'($urandom));
        cycle(1'b1, 1'b1, 1'b0, 1'b0, CN'($urandom));
        cycle(1'b0, 1'b1, 1'b0, 1'b0, CN'($urandom));
        cycle(1'b0, 1'b1, 1'b0, 1'b0, CN'($urandom));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, CN'($urandom));
        check("parity_reject_err", sel_err, 1);
        check("parity_reject_sel", sel_active, 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, CN'($urandom));
        cycle(1'b1, 1'b1, 1'b0, 1'b0, CN'($urandom));
        cycle(1'b0, 1'b1, 1'b0, 1'b0, CN'($urandom));
        cycle(1'b1, 1'b1, 1'b0, 1'b0, CN'($urandom));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, CN'($urandom));
        check("parity_accept_err", sel_err, 0);
        check("parity_accept_sel", sel_active, 2);
`endif

        for (int n = 0; n < 600; n++) begin
            if (n % 97 == 50) begin
                rst_pulse();
            end else begin
                cycle(1'($urandom), ($urandom % 4) == 0, ($urandom % 5) == 0,
                      ($urandom % 3) != 0, CN'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bsr_chain_select.md
BSR_CHAIN_SELECT -- requirements
Module: bsr_chain_select

Interface
REQ-001 SHALL have parameter CHAIN_NUM, default 4: number of boundary-scan chains, minimum 1.
REQ-002 SHALL have parameter SEL_WIDTH, default $clog2(CHAIN_NUM+1): select code width; the all-ones code is reserved for CONCAT.
REQ-003 SHALL have port tck, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port tdi, input, 1: serial scan data in.
REQ-006 SHALL have port shift_sel, input, 1: shift the select shift register.
REQ-007 SHALL have port update_sel, input, 1: transfer the select shift register into the active select.
REQ-008 SHALL have port shift_dr, input, 1: shift the data path.
REQ-009 SHALL have port bsr_so, input, CHAIN_NUM: chain serial outputs.
REQ-010 SHALL have port bsr_si, output, CHAIN_NUM: chain serial inputs.
REQ-011 SHALL have port chain_shift_en, output, CHAIN_NUM: per-chain shift enables.
REQ-012 SHALL have port scan_out, output, 1: registered serial output.
REQ-013 SHALL have port sel_active, output, SEL_WIDTH: current active select code.
REQ-014 SHALL have port sel_err, output, 1: last update rejected or out of range.

Function
REQ-015 Select shift register (sr) SHALL shift LSB-first when shift_sel=1: sr <= {tdi, sr[MSB:1]}.
REQ-016 When update_sel=1 and shift_sel=0, the active select SHALL load sr on that edge; the mode SHALL take effect the next cycle.
REQ-017 When update_sel=1 and shift_sel=1 in the same cycle, the shift SHALL occur and the update SHALL be ignored.
REQ-018 Active code below CHAIN_NUM SHALL select MODE_SINGLE chain k.
REQ-019 Active code all-ones SHALL select MODE_CONCAT.
REQ-020 Any other active code SHALL select MODE_BYPASS, and sel_err SHALL be 1.
REQ-021 sel_err SHALL clear on the next accepted in-range update.
REQ-022 MODE_SINGLE routing:
- bsr_si[k] = tdi; chain_shift_en[k] = shift_dr; all other enables 0.
- Data source = bsr_so[k].
REQ-023 MODE_CONCAT routing:
- bsr_si[0] = tdi; bsr_si[i] = bsr_so[i-1] for i > 0.
- All enables = shift_dr.
- Data source = bsr_so[CHAIN_NUM-1].
REQ-024 MODE_BYPASS: bypass flop SHALL load tdi when shift_dr=1; data source = bypass flop; all enables 0.
REQ-025 Unused bsr_si bits SHALL drive 0.
REQ-026 scan_out SHALL update on each edge by priority:
- shift_sel=1: sr[0], the value before the shift.
- else shift_dr=1: data source.
- else hold.
REQ-027 While shift_sel=1, all chain_shift_en SHALL be 0, even if shift_dr=1.
REQ-028 Latency: chain data SHALL appear on scan_out one cycle after shift_dr; bypass data two cycles after tdi.
REQ-029 For CHAIN_NUM=1, code 0 SHALL be SINGLE and code 1 SHALL be CONCAT, which is functionally identical.

Reset
REQ-030 While rst=1, the following SHALL be 0 asynchronously: sr, active select (chain 0, MODE_SINGLE), bypass flop, scan_out, sel_err.
REQ-031 Reset asserted mid-shift SHALL discard partial sr content; no update SHALL follow reset release without a new update_sel.

Configuration
REQ-032 With BSR_SEL_PARITY_EN defined:
- sr SHALL be SEL_WIDTH+1 bits; the parity bit is the MSB, shifted last.
- Update SHALL be accepted only if the XOR of all sr bits is 0 (even parity).
- On rejection, the active select SHALL be unchanged and sel_err SHALL be set to 1.
REQ-033 Without BSR_SEL_PARITY_EN, sr SHALL be SEL_WIDTH bits and there SHALL be no parity check.

Structure
REQ-034 Package bsr_pkg SHALL hold:
- enum bsr_mode_e {MODE_SINGLE, MODE_CONCAT, MODE_BYPASS}.
- The concat-code constant function.
REQ-035 Sub-module bsr_sel_reg SHALL implement sr, update, parity check and sel_err; the routing and data path stay in the top level.

Verification (CHAIN_NUM=4, SEL_WIDTH=3)
REQ-036 Reset, then shift_dr=1 with bsr_so=4'b0001 -> chain_shift_en=4'b0001; scan_out=1 one cycle later.
REQ-037 Shift tdi 0,1,0 with shift_sel=1, then update_sel -> sel_active=3'b010, chain_shift_en=4'b0100, bsr_so[2]=1 gives scan_out=1.
REQ-038 Load 3'b111 -> chain_shift_en=4'b1111, bsr_si[1]=bsr_so[0], scan_out follows bsr_so[3] with a 1-cycle lag.
REQ-039 Load 3'b101 -> sel_err=1, enables 0; tdi 1,0,1 appears on scan_out 2 cycles later; a following load of 3'b000 clears sel_err.
REQ-040 shift_sel and update_sel high together -> sel_active unchanged; rst pulse mid-shift -> scan_out=0 and sel_active=0 with no tck edge.
REQ-041 BSR_SEL_PARITY_EN: load 3'b010 with parity bit 0 -> rejected, sel_err=1, sel_active unchanged; the same code with parity bit 1 -> accepted.
